// File: rtl/mbscore_intc_vec_pkg.sv
// Shared constants for the MBScore vectored interrupt controller: legacy source ids,
// default vector table placement and controller FSM state encodings.
package mbscore_intc_vec_pkg;

    localparam int INT_KEYBOARD = 0;
    localparam int INT_TIMER    = 1;
    localparam int INT_UART     = 2;
    localparam int INT_DISK     = 3;
    localparam int INT_NET      = 4;
    localparam int INT_DMA      = 5;
    localparam int INT_SYSCALL  = 6;

    localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0100;
    localparam int          DEF_VEC_STRIDE = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STOP    = 2'd1,
        ST_JUMP    = 2'd2,
        ST_SERVICE = 2'd3
    } state_t;

endpackage

// File: rtl/mbscore_prio_enc.sv
// Lowest-index priority encoder: vld when any request bit is set, id of the lowest set bit.
// Purely combinational, zero latency; no flow control.
// Bit 0 always wins, so callers map priority onto index order.
module mbscore_prio_enc #(
    parameter int W    = 8,
    parameter int ID_W = 3
) (
    input  logic [W-1:0]    req,
    output logic            vld,
    output logic [ID_W-1:0] id
);

    always_comb begin
        id = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) id = ID_W'(i);
        end
    end

    assign vld = |req;

endmodule

// File: rtl/mbscore_intc_vec.sv
// Vectored interrupt controller: edge capture, masking, fixed-priority arbitration, stop/jump/ack/service handshake.
// Edge to int_jump is 3 cycles; int_jump is held until int_ack, setINTR held until the final int_ret.
// Optional nested preemption is enabled by defining MBSCORE_INTC_NEST_EN.
module mbscore_intc_vec
    import mbscore_intc_vec_pkg::*;
#(
    parameter int                    NUM_SRC    = 8,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] VEC_BASE   = ADDR_WIDTH'(DEF_VEC_BASE),
    parameter int                    VEC_STRIDE = DEF_VEC_STRIDE,
    localparam int                   ID_W       = $clog2(NUM_SRC > 1 ? NUM_SRC : 2)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_SRC-1:0]    int_vec,
    input  logic [NUM_SRC-1:0]    int_mask,
    input  logic                  int_en_n,
    input  logic                  int_ack,
    input  logic                  int_ret,
    output logic                  stop,
    output logic                  int_jump,
    output logic [ADDR_WIDTH-1:0] int_addr,
    output logic [ID_W-1:0]       int_id,
    output logic                  setINTR
);

    state_t                state;
    state_t                state_nxt;
    logic [NUM_SRC-1:0]    vec_q;
    logic                  armed;
    logic [NUM_SRC-1:0]    rise;
    logic [NUM_SRC-1:0]    pend;
    logic [NUM_SRC-1:0]    pend_nxt;
    logic [NUM_SRC-1:0]    isr;
    logic [NUM_SRC-1:0]    isr_nxt;
    logic [NUM_SRC-1:0]    isr_left;
    logic [NUM_SRC-1:0]    elig;
    logic [NUM_SRC-1:0]    sel_oh;
    logic                  elig_vld;
    logic [ID_W-1:0]       elig_id;
    logic [ID_W-1:0]       sel_id;
    logic [ID_W-1:0]       svc_id;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_calc;
    logic                  take;
    logic                  preempt;
    logic                  ack_hit;
    logic                  ret_hit;

    // The first cycle after reset only records history, so a line held high through reset is not an edge.
    assign rise    = armed ? (int_vec & ~vec_q) : '0;
    assign elig    = pend & ~int_mask;
    assign ack_hit = (state == ST_JUMP) && int_ack;
    assign ret_hit = (state == ST_SERVICE) && int_ret;
    assign sel_oh  = NUM_SRC'(1) << sel_id;

    assign addr_calc = VEC_BASE + ADDR_WIDTH'(elig_id) * ADDR_WIDTH'(VEC_STRIDE);

    mbscore_prio_enc #(.W(NUM_SRC), .ID_W(ID_W)) u_elig_enc (
        .req (elig),
        .vld (elig_vld),
        .id  (elig_id)
    );

`ifdef MBSCORE_INTC_NEST_EN
    logic            isr_vld;
    logic [ID_W-1:0] isr_id;

    mbscore_prio_enc #(.W(NUM_SRC), .ID_W(ID_W)) u_isr_enc (
        .req (isr),
        .vld (isr_vld),
        .id  (isr_id)
    );

    // Return retires the highest-priority (lowest index) handler still in service.
    assign isr_left = isr & (isr - NUM_SRC'(1));
    assign preempt  = !int_en_n && elig_vld && isr_vld && (elig_id < isr_id);
    assign svc_id   = isr_id;
`else
    assign isr_left = '0;
    assign preempt  = 1'b0;
    assign svc_id   = sel_id;
`endif

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!int_en_n && elig_vld) begin
                    state_nxt = ST_STOP;
                    take      = 1'b1;
                end
            end
            ST_STOP:    state_nxt = ST_JUMP;
            ST_JUMP: begin
                if (int_ack) state_nxt = ST_SERVICE;
            end
            ST_SERVICE: begin
                if (int_ret) begin
                    if (isr_left == '0) state_nxt = ST_IDLE;
                end else if (preempt) begin
                    state_nxt = ST_STOP;
                    take      = 1'b1;
                end
            end
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // A fresh edge in the ack cycle re-arms the source rather than being lost.
    always_comb begin
        pend_nxt = (pend & ~(ack_hit ? sel_oh : '0)) | rise;
        isr_nxt  = isr;
        if (ack_hit) begin
            isr_nxt = isr | sel_oh;
        end else if (ret_hit) begin
            isr_nxt = isr_left;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q  <= '0;
            armed  <= 1'b0;
            pend   <= '0;
            isr    <= '0;
            sel_id <= '0;
            addr_q <= '0;
        end else begin
            vec_q  <= int_vec;
            armed  <= 1'b1;
            pend   <= pend_nxt;
            isr    <= isr_nxt;
            if (take) begin
                sel_id <= elig_id;
                addr_q <= addr_calc;
            end
        end
    end

    assign stop     = (state == ST_STOP) || (state == ST_JUMP);
    assign int_jump = (state == ST_JUMP);
    assign int_addr = int_jump ? addr_q : '0;
    assign setINTR  = |isr;

    always_comb begin
        case (state)
            ST_IDLE:    int_id = '0;
            ST_SERVICE: int_id = svc_id;
            default:    int_id = sel_id;
        endcase
    end

endmodule

// File: doc/mbscore_intc_vec.md
# mbscore_intc_vec

Parametrised, vectored interrupt controller for the MBScore CPU, successor to the fixed seven-source controller. It edge-captures `NUM_SRC` interrupt lines into sticky pending bits and masks them per source. It arbitrates by fixed priority, then runs a stop → jump → acknowledge → in-service handshake with the core pipeline. It sits between the SoC peripheral interrupt lines and the core's PC-redirect / pipeline-stall logic.

## Interface
- `NUM_SRC`, 8: number of interrupt sources, 1..32; bit 0 is highest priority.
- `ADDR_WIDTH`, 32: vector address width.
- `VEC_BASE`, 32'h0000_0100: address of vector 0.
- `VEC_STRIDE`, 16: byte distance between consecutive vectors.
- `clk  in  1`: core clock; all state on rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `int_vec  in  NUM_SRC`: raw interrupt lines, synchronous to `clk`.
- `int_mask  in  NUM_SRC`: 1 = source masked, excluded from arbitration; its pending bit still captures.
- `int_en_n  in  1`: global enable, active-low; high blocks new arbitration only.
- `int_ack  in  1`: one-cycle pulse from the core, meaning the vector was taken (PC redirected).
- `int_ret  in  1`: one-cycle pulse from the core on handler return.
- `stop  out  1`: stall/drain request to the pipeline.
- `int_jump  out  1`: vector valid; held until `int_ack`.
- `int_addr  out  ADDR_WIDTH`: `VEC_BASE + id*VEC_STRIDE`; zero when `int_jump`=0.
- `int_id  out  $clog2(NUM_SRC)` (min 1): id being jumped to or serviced.
- `setINTR  out  1`: in-service flag; 1 from the ack until the final `int_ret`.

## Operation
- **Capture:**
  - A rising edge of `int_vec[i]`, detected against a registered copy, sets `pend[i]`.
  - `pend[i]` clears only in the cycle `int_ack` accepts id i.
  - A new edge in that same cycle wins, so `pend[i]` stays 1.
- **Eligibility:** `elig = pend & ~int_mask`. The winner is the lowest set index.
- **FSM states:** IDLE, STOP, JUMP, SERVICE.
- **Transitions:**
  - IDLE → STOP when `elig`≠0 and `int_en_n`=0. The winner id is latched into `sel_id`.
  - STOP → JUMP unconditionally after 1 cycle.
  - JUMP → SERVICE on `int_ack`: clear `pend[sel_id]`, set `isr[sel_id]`.
  - SERVICE → IDLE on `int_ret`, when `isr` becomes 0.
- **Outputs per state:**
  - `stop` = 1 in STOP and JUMP.
  - `int_jump` = 1 in JUMP only.
  - `int_addr` and `int_id` are computed from the latched `sel_id`.
- **Latched selection:** mask or enable changes during STOP/JUMP do not alter the chosen id or abort the jump.
- **Ignored pulses:** `int_ack` outside JUMP, and `int_ret` in IDLE/STOP/JUMP (without nesting).
- **Arithmetic:** address computed in `ADDR_WIDTH` bits, modulo 2^`ADDR_WIDTH` (wrap-around permitted).
- **Reset:** asynchronous.
  - Cleared: all outputs, `pend`, `isr`, `sel_id`, edge-detect history; state returns to IDLE.
  - A line held high through reset deasserting is not an edge. It needs a fall then a rise to be captured.

## Timing
- Edge visible on `int_vec` at cycle t: `pend` set at t+1, `stop`=1 at t+2, `int_jump`/`int_addr` valid at t+3.
- Ack in cycle a: `setINTR`=1 and `int_jump`=0 at a+1.
- After the final `int_ret` in cycle r: IDLE at r+1; next arbitration produces `stop` at r+2.
- Back-to-back interrupts are therefore separated by at least 2 idle cycles of `stop`.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- **`MBSCORE_INTC_NEST_EN` defined:**
  - In SERVICE, an eligible id with higher priority than the highest set `isr` bit preempts. The FSM goes SERVICE → STOP, and the next ack sets an additional `isr` bit.
  - `int_ret` clears the highest-priority set `isr` bit. `int_id` then reports the next remaining `isr` bit.
  - FSM returns to IDLE when `isr` becomes 0.
- **Undefined:**
  - `isr` holds at most one bit; there is no arbitration in SERVICE.
  - The first `int_ret` returns the FSM to IDLE.

## Structure
- **Shared package/const file (`MBScore_const.v`):**
  - Source index defines (`INT_KEYBOARD`=0 … `INT_SYSCALL`=6).
  - Default `VEC_BASE`/`VEC_STRIDE`.
  - FSM state encodings.
- **Sub-module `mbscore_prio_enc`:** parametrised lowest-index priority encoder (valid + id). Instantiated once for `elig`; under the nesting macro, a second instance serves `isr`.

## Test plan
- **Single source, NUM_SRC=8, VEC_BASE=0x100:** pulse `int_vec[2]` at t → `stop` at t+2, `int_jump` at t+3 with `int_addr`=0x120, `int_id`=2. Ack → `setINTR`=1. `int_ret` → IDLE, `pend`=0.
- **Priority and pending retention:** edges on bits 5 and 1 in the same cycle → id 1 served first (0x110). After `int_ret`, id 5 (0x150) is served without a new edge.
- **Mask and enable:**
  - `int_mask[3]`=1, edge on bit 3 → no `stop`; clear mask → served 3 cycles later.
  - `int_en_n`=1 → no `stop` while pending.
- **Edge collision:** new edge on bit 4 in the same cycle as the ack of id 4 → `pend[4]` stays 1; id 4 is re-served after `int_ret`.
- **Reset mid-JUMP:** `rst_n`=0 while `int_jump`=1 → all outputs 0 immediately. A line held high across reset is not re-captured.
- **Nesting (macro on):**
  - In service of id 6, edge on id 0 → preempt to 0x100, `isr`=0x41.
  - First `int_ret` → `int_id`=6, `setINTR` stays 1.
  - Second `int_ret` → IDLE.
  - With the macro off, the same stimulus serves id 0 only after the first `int_ret`.
